cfo_ctrl: RTL and testbench

Sequencing controller for the CFO-estimation datapath.
- On a `start` request it clears the accumulator register and sample counter, then streams the `Ng` cyclic-prefix sample pairs through the complex multiply/accumulate path.
- It then drains the multiplier pipeline, fires one arctangent request, and captures the resulting 12-bit CFO.
- It sits between the frame-sync logic (source of `start`) and the datapath, driving every datapath control input and reporting `busy`/`done`/`err`.

---
 rtl/cfo_ctrl_pkg.sv | 80 ++++++++
 rtl/cfo_ctrl_ld_delay.sv | 38 +++
 rtl/cfo_ctrl.sv | 176 +++++++++++++++++
 tb/tb_cfo_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cfo_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cfo_ctrl_pkg
// Shared definitions for the CFO-estimation sequencing controller:
//   - state_e     : controller FSM states
//   - ctrl_t      : bundle of per-state datapath control levels
//   - CFO_W_DEF   : default CFO word width
//   - wdog_width  : counter width able to hold (limit - 1), at least one bit
//   - ctrl_decode : control levels that belong to a given state
// -----------------------------------------------------------------------------
package cfo_ctrl_pkg;

    localparam int CFO_W_DEF = 12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        ACC   = 3'd2,
        DRAIN = 3'd3,
        ATAN  = 3'd4,
        WAIT  = 3'd5
    } state_e;

    typedef struct packed {
        logic reg_rst;
        logic cnt_rst;
        logic cen;
        logic mode;
        logic t_valid;
        logic busy;
    } ctrl_t;

    // Width of a counter that must reach limit-1 (clog2 of limit, never zero).
    function automatic int wdog_width(input int limit);
        int w;
        w = $clog2(limit);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

    // Control levels that are valid while the FSM sits in state st.
    function automatic ctrl_t ctrl_decode(input state_e st);
        ctrl_t c;
        c = '0;
        case (st)
            IDLE: begin
                c = '0;
            end
            CLR: begin
                c.reg_rst = 1'b1;
                c.cnt_rst = 1'b1;
                c.busy    = 1'b1;
            end
            ACC: begin
                c.cen  = 1'b1;
                c.mode = 1'b1;
                c.busy = 1'b1;
            end
            DRAIN: begin
                c.mode = 1'b1;
                c.busy = 1'b1;
            end
            ATAN: begin
                c.t_valid = 1'b1;
                c.busy    = 1'b1;
            end
            WAIT: begin
                c.busy = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cfo_ctrl_ld_delay.sv
// -----------------------------------------------------------------------------
// ld_delay
// DEPTH-stage shift register that turns the sample-counter enable into the
// accumulator load strobe, so each load lines up with its product leaving the
// multiplier pipeline.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   clr  : synchronous flush of every stage (start of run / abort)
//   din  : cen from the controller
//   dout : reg_ld, din delayed by DEPTH cycles
// -----------------------------------------------------------------------------
module ld_delay #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sreg_r;

    // Shift the enable through the pipeline; reset and flush both empty it.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sreg_r <= '0;
        end else begin
            sreg_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                sreg_r[i] <= sreg_r[i-1];
            end
        end
    end

    assign dout = sreg_r[DEPTH-1];

endmodule

// File: rtl/cfo_ctrl.sv
// -----------------------------------------------------------------------------
// cfo_ctrl
// Sequencer for the CFO-estimation datapath. A start request clears the
// accumulator and sample counter, streams Ng cyclic-prefix sample pairs
// through the multiply/accumulate path, drains the multiplier pipeline,
// issues one arctangent request and captures the returned CFO word.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   start      : begin one estimation (only honoured in IDLE)
//   abort      : cancel the running estimation
//   cntf       : datapath sample counter holds Ng-1
//   out_valid  : datapath CFO result valid
//   cfo_in     : datapath CFO result
//   reg_rst    : accumulator clear
//   reg_ld     : accumulator load (cen delayed by PIPE)
//   cnt_rst    : sample counter clear
//   cen        : sample counter enable
//   mode       : sample memory read select, 1 while accumulating/draining
//   t_valid    : arctangent request, one cycle
//   busy       : high outside IDLE
//   done       : one-cycle pulse, cfo_out just updated
//   err        : one-cycle pulse, arctangent result timed out
//   cfo_out    : last captured CFO word
// -----------------------------------------------------------------------------
module cfo_ctrl
    import cfo_ctrl_pkg::*;
#(
    parameter int PIPE    = 2,
    parameter int TIMEOUT = 64,
    parameter int CFO_W   = CFO_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             cntf,
    input  logic             out_valid,
    input  logic [CFO_W-1:0] cfo_in,
    output logic             reg_rst,
    output logic             reg_ld,
    output logic             cnt_rst,
    output logic             cen,
    output logic             mode,
    output logic             t_valid,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CFO_W-1:0] cfo_out
);

    localparam int WDOG_W  = wdog_width(TIMEOUT);
    localparam int DRAIN_W = wdog_width(PIPE);

    localparam logic [WDOG_W-1:0]  WDOG_LAST  = WDOG_W'(TIMEOUT - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPE - 1);

    state_e             state_r;
    ctrl_t              ctrl_r;
    logic               done_r;
    logic               err_r;
    logic [CFO_W-1:0]   cfo_r;
    logic [DRAIN_W-1:0] drain_cnt_r;
    logic [WDOG_W-1:0]  wdog_r;

    logic               abort_hit_s;
    logic               ld_clr_s;

    // Abort only counts once an estimation is underway.
    assign abort_hit_s = abort && (state_r != IDLE);

    // The load pipeline is flushed when a run starts and when it is cancelled.
    assign ld_clr_s = (state_r == CLR) || abort_hit_s;

    // Sequencing FSM; control levels are loaded together with the next state
    // so every output comes straight from a flop without adding latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            ctrl_r      <= '0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            cfo_r       <= '0;
            drain_cnt_r <= '0;
            wdog_r      <= '0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            if (abort_hit_s) begin
                // Abort beats every other event; result and flags untouched.
                state_r <= IDLE;
                ctrl_r  <= ctrl_decode(IDLE);
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start) begin
                            state_r <= CLR;
                            ctrl_r  <= ctrl_decode(CLR);
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    CLR: begin
                        state_r <= ACC;
                        ctrl_r  <= ctrl_decode(ACC);
                    end
                    ACC: begin
                        // cntf marks the Ng-th enabled cycle.
                        if (cntf) begin
                            state_r     <= DRAIN;
                            ctrl_r      <= ctrl_decode(DRAIN);
                            drain_cnt_r <= '0;
                        end else begin
                            state_r <= ACC;
                        end
                    end
                    DRAIN: begin
                        // Hold PIPE cycles so the last product reaches the adder.
                        if (drain_cnt_r == DRAIN_LAST) begin
                            state_r <= ATAN;
                            ctrl_r  <= ctrl_decode(ATAN);
                        end else begin
                            drain_cnt_r <= drain_cnt_r + DRAIN_W'(1);
                        end
                    end
                    ATAN: begin
                        state_r <= WAIT;
                        ctrl_r  <= ctrl_decode(WAIT);
                        wdog_r  <= '0;
                    end
                    WAIT: begin
                        // A result on the last allowed cycle still counts.
                        if (out_valid) begin
                            cfo_r   <= cfo_in;
                            done_r  <= 1'b1;
                            state_r <= IDLE;
                            ctrl_r  <= ctrl_decode(IDLE);
                        end else if (wdog_r == WDOG_LAST) begin
                            err_r   <= 1'b1;
                            state_r <= IDLE;
                            ctrl_r  <= ctrl_decode(IDLE);
                        end else begin
                            wdog_r <= wdog_r + WDOG_W'(1);
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        ctrl_r  <= ctrl_decode(IDLE);
                    end
                endcase
            end
        end
    end

    ld_delay #(
        .DEPTH (PIPE)
    ) u_ld_delay (
        .clk  (clk),
        .rst  (rst),
        .clr  (ld_clr_s),
        .din  (ctrl_r.cen),
        .dout (reg_ld)
    );

    assign reg_rst = ctrl_r.reg_rst;
    assign cnt_rst = ctrl_r.cnt_rst;
    assign cen     = ctrl_r.cen;
    assign mode    = ctrl_r.mode;
    assign t_valid = ctrl_r.t_valid;
    assign busy    = ctrl_r.busy;
    assign done    = done_r;
    assign err     = err_r;
    assign cfo_out = cfo_r;

endmodule

// File: tb/tb_cfo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cfo_ctrl
// Self-checking bench for cfo_ctrl. Each estimation is described by a few
// numbers (Ng, result delay after t_valid, CFO word, abort/reset cycle, stray
// events). Expected outputs for every cycle are derived from the timing rules:
// relative to the edge that samples start, CLR is cycle 1, ACC cycles 2..1+Ng,
// DRAIN up to 1+Ng+PIPE, t_valid at 2+Ng+PIPE, loads at 2+PIPE..1+Ng+PIPE,
// and done/err one cycle after the result or the watchdog limit.
// -----------------------------------------------------------------------------
module tb_cfo_ctrl;

    localparam int PIPE    = 2;
    localparam int TIMEOUT = 8;
    localparam int CFO_W   = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic             cntf;
    logic             out_valid;
    logic [CFO_W-1:0] cfo_in;
    logic             reg_rst;
    logic             reg_ld;
    logic             cnt_rst;
    logic             cen;
    logic             mode;
    logic             t_valid;
    logic             busy;
    logic             done;
    logic             err;
    logic [CFO_W-1:0] cfo_out;

    int               n_assert = 0;
    int               n_fail   = 0;
    int               ng_cur   = 16;
    int               dp_cnt   = 0;
    logic [CFO_W-1:0] cfo_model = '0;

    cfo_ctrl #(
        .PIPE    (PIPE),
        .TIMEOUT (TIMEOUT),
        .CFO_W   (CFO_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .cntf      (cntf),
        .out_valid (out_valid),
        .cfo_in    (cfo_in),
        .reg_rst   (reg_rst),
        .reg_ld    (reg_ld),
        .cnt_rst   (cnt_rst),
        .cen       (cen),
        .mode      (mode),
        .t_valid   (t_valid),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cfo_out   (cfo_out)
    );

    always #5 clk = ~clk;

    // Datapath sample counter: cleared by cnt_rst, counts enabled cycles.
    always @(posedge clk) begin
        if (cnt_rst) dp_cnt <= 0;
        else if (cen) dp_cnt <= dp_cnt + 1;
    end

    assign cntf = (dp_cnt == ng_cur - 1);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [8:0] obs_ctrl();
        return {reg_rst, reg_ld, cnt_rst, cen, mode, t_valid, busy, done, err};
    endfunction

    // One estimation. ov_off: result delay after t_valid (0 = never).
    // kill_r: cycle carrying abort (or rst when kill_rst), 0 = none.
    task automatic run_est(input string name, input int ng, input int ov_off,
                           input logic [CFO_W-1:0] cfo, input int kill_r,
                           input bit kill_rst, input int s_start_a,
                           input int s_start_b, input int s_ov);
        int r_t, r_v, r_end, r_stop;
        bit success, killed, live;
        logic [CFO_W-1:0] cfo_old, cfo_new, cfo_exp;
        logic [8:0] ec;

        r_t     = 2 + ng + PIPE;
        r_v     = (ov_off > 0) ? r_t + ov_off : 0;
        success = (ov_off > 0) && (ov_off <= TIMEOUT);
        r_end   = success ? r_v + 1 : r_t + TIMEOUT + 1;
        killed  = (kill_r > 0) && (kill_r < r_end);
        r_stop  = r_end;
        if (r_v > r_stop) r_stop = r_v;
        if (killed) r_stop = kill_r + 1;
        cfo_old = cfo_model;
        cfo_new = success ? cfo : cfo_old;
        if (killed) cfo_new = kill_rst ? '0 : cfo_old;

        ng_cur = ng;
        cfo_in = cfo;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int r = 1; r <= r_stop; r++) begin
            start     = (r == s_start_a) || (r == s_start_b);
            out_valid = (r == r_v) || (r == s_ov);
            abort     = (r == kill_r) && !kill_rst;
            rst       = (r == kill_r) && kill_rst;
            live      = !killed || (r <= kill_r);
            ec[8] = live && (r == 1);
            ec[7] = live && (r >= 2 + PIPE) && (r <= 1 + ng + PIPE);
            ec[6] = live && (r == 1);
            ec[5] = live && (r >= 2) && (r <= 1 + ng);
            ec[4] = live && (r >= 2) && (r <= 1 + ng + PIPE);
            ec[3] = live && (r == r_t);
            ec[2] = live && (r < r_end);
            ec[1] = live && success && (r == r_end);
            ec[0] = live && !success && (r == r_end);
            if (killed && (r > kill_r)) cfo_exp = cfo_new;
            else if (!killed && (r >= r_end)) cfo_exp = cfo_new;
            else cfo_exp = cfo_old;
            chk($sformatf("%s ctrl r=%0d", name, r), {23'd0, obs_ctrl()}, {23'd0, ec});
            chk($sformatf("%s cfo_out r=%0d", name, r), {20'd0, cfo_out}, {20'd0, cfo_exp});
            if (r < r_stop) tick();
        end
        start     = 1'b0;
        out_valid = 1'b0;
        abort     = 1'b0;
        rst       = 1'b0;
        cfo_model = cfo_new;
    endtask

    initial begin
        int ng, ov, kr, rt;
        logic [CFO_W-1:0] rc;

        rst = 1'b1; start = 1'b0; abort = 1'b0; out_valid = 1'b0; cfo_in = '0;
        tick(); tick(); tick();
        chk("reset ctrl", {23'd0, obs_ctrl()}, 32'd0);
        chk("reset cfo_out", {20'd0, cfo_out}, 32'd0);
        rst = 1'b0;
        tick();
        chk("idle ctrl", {23'd0, obs_ctrl()}, 32'd0);

        // abort while idle does nothing
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        chk("idle abort ctrl", {23'd0, obs_ctrl()}, 32'd0);
        chk("idle abort cfo", {20'd0, cfo_out}, 32'd0);

        // nominal, then timeout chained straight off the done cycle
        run_est("nominal", 16, 3, 12'h0A5, 0, 1'b0, 0, 0, 0);
        run_est("timeout", 16, 0, 12'h3C3, 0, 1'b0, 0, 0, 0);
        // abort in the 5th ACC cycle, then restart
        run_est("abort_acc", 16, 3, 12'h111, 6, 1'b0, 0, 0, 0);
        run_est("restart", 16, 3, 12'h5A7, 0, 1'b0, 0, 0, 0);
        // busy starts in ACC and WAIT, stray result in DRAIN
        run_est("stray", 16, 4, 12'h777, 0, 1'b0, 8, 22, 19);
        // reset in the first DRAIN cycle
        run_est("rst_drain", 16, 3, 12'h222, 18, 1'b1, 0, 0, 0);
        // result on the timeout cycle is a success
        run_est("ov_at_timeout", 16, TIMEOUT, 12'h9E1, 0, 1'b0, 0, 0, 0);
        // abort together with the result
        run_est("abort_ov", 16, 3, 12'h444, 2 + 16 + PIPE + 3, 1'b0, 0, 0, 0);
        // result during ATAN is ignored, run times out
        run_est("ov_in_atan", 4, 0, 12'h0F0, 0, 1'b0, 0, 0, 2 + 4 + PIPE);

        // randomized runs
        for (int i = 0; i < 10; i++) begin
            ng = $urandom_range(20, 1);
            ov = $urandom_range(TIMEOUT + 3, 0);
            rc = CFO_W'($urandom);
            rt = 2 + ng + PIPE;
            kr = (($urandom & 32'd3) == 32'd0) ? $urandom_range(rt + 1, 1) : 0;
            run_est($sformatf("rand%0d", i), ng, ov, rc, kr, 1'b0, 0, 0, 0);
        end

        tick();
        chk("final idle ctrl", {23'd0, obs_ctrl()}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
